mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port byte-addressed memory shared by the cpu0 core (requester 0) and a DMA/IO master (requester 1).
- Grants one requester at a time using round-robin, then drives the memory enable/rw/size/address/data strobes for a fixed access window.
- Captures read data from the memory data bus and returns a one-cycle completion pulse to the winner.
- Sits between the masters and memory0, replacing the direct cpu-to-memory strobe connection.

Parameters:
- ACCESS_CYCLES, 1: cycles m_en is held per access; legal range 1..15.
- MEM_TOP, 1023: highest legal byte address. Accesses above it are not issued to memory.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request from requester 0 / 1; held high until the matching gnt.
- rw0 / rw1  in  1  1 = read, 0 = write.
- size0 / size1  in  2  00 = byte, 01 = 16 bits, 10 = 24 bits, 11 = 32 bits.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  one-cycle pulse: command captured.
- done0 / done1  out  1  one-cycle pulse: access complete; rdata/err valid.
- rdata  out  32  read data, held until the next read completes.
- err  out  1  valid with done: address exceeded MEM_TOP.
- m_en, m_rw  out  1  memory enable; memory mode (1 = read).
- m_size  out  2  memory access size.
- mar  out  32  memory address.
- mdr  out  32  memory write data.
- dbus  in  32  memory read data.

Behaviour:
Reset (reset low, asynchronous):
- State goes to IDLE; last = 1, so requester 0 wins the first tie.
- All gnt/done/err low, m_en = 0, m_rw = 1, m_size = 00, mar = mdr = rdata = 0, access counter = 0.
- A transaction in flight is abandoned: no done pulse, m_en drops immediately.

State IDLE:
- No request: stay in IDLE.
- Exactly one request: grant that requester.
- Both requesting: grant the requester other than last.
- On grant:
  - pulse gnt for the transfer cycle;
  - register rw/size/addr/wdata into mar, mdr, m_rw, m_size;
  - set last = winner;
  - load counter = ACCESS_CYCLES.
- Next state: ACCESS if addr <= MEM_TOP, otherwise DONE with err pending.

State ACCESS:
- m_en = 1; mar, mdr, m_rw and m_size stay stable for the whole window.
- Counter decrements every cycle.
- Last cycle of the window (counter == 1):
  - for a read, rdata <= dbus;
  - next state DONE.

State DONE (exactly one cycle):
- m_en = 0.
- Pulse done of the registered winner; err = 1 only for an out-of-range access.
- rdata is unchanged on writes and on errors.
- Next state IDLE.
- Requests seen during DONE are not arbitrated until IDLE.

Timing:
- Minimum occupancy per transaction is ACCESS_CYCLES + 2 cycles.
- The request-to-done latency is ACCESS_CYCLES + 2 cycles, counted from the rising edge that samples req in IDLE.

Handshake rules:
- A requester may drop req or change its command once gnt has been seen.
- After gnt, req must not be raised again for that requester before its done.
- A req that drops before gnt is simply not served; there is no error.
- gnt0 and gnt1 are never high together; the same holds for done0 and done1.

Address and width rules:
- The address comparison is unsigned 32-bit.
- Sizes narrower than 32 bits are passed through unchanged; the memory handles them.
- Arithmetic on the counter saturates at 0 and never wraps.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both request. The last register still updates but is ignored.
- Not defined: round-robin as described above.
- All ports and all timing are identical in both builds.

Test Plan:
1. Single read: req0 with addr 0x10, size 11, memory word 0xDEADBEEF, ACCESS_CYCLES = 1.
   -> gnt0 in cycle 1; m_en high in cycle 2 only; done0 in cycle 3; rdata = 0xDEADBEEF.
2. Single write: req1 with addr 0x20, wdata 0x12345678, size 11.
   -> mar = 0x20, mdr = 0x12345678 and m_rw = 0 while m_en is high; done1 pulses; rdata unchanged.
3. Simultaneous requests: req0 and req1 held high continuously after reset for 4 transactions.
   -> grant order 0, 1, 0, 1; with MEM_ARB_FIXED_PRIO_EN the order is 0, 0, 0, 0.
4. Out-of-range access: req0 with addr 0x400.
   -> no m_en pulse; done0 with err = 1 two cycles after the sampling edge; rdata unchanged.
5. Reset mid-operation: ACCESS_CYCLES = 3 and reset low during the second ACCESS cycle.
   -> m_en = 0 immediately; no done pulse; the next tie after reset is granted to requester 0.
6. Longer window: ACCESS_CYCLES = 4, byte read at 0x3FF.
   -> m_en high for exactly 4 cycles; done0 six cycles after the sampling edge; rdata = {24'h0, m[0x3FF]}.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-requester memory arbiter and fixed-window access sequencer
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module mem_bus_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned MEM_TOP       = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        rw0,
    input  logic        rw1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        m_en,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] mar,
    output logic [31:0] mdr,
    input  logic [31:0] dbus
);
    localparam logic [3:0]  CNT_LOAD = 4'(ACCESS_CYCLES);
    localparam logic [31:0] ADDR_TOP = 32'(MEM_TOP);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    logic        last;
    logic        owner;
    logic        err_pend;
    logic [3:0]  cnt;

    logic        any_req;
    logic        winner;
    logic        sel_rw;
    logic        sel_oor;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    always_comb begin
        any_req = req0 | req1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        winner = ~req0;
`else
        winner = (req0 && req1) ? ~last : req1;
`endif
        sel_rw    = winner ? rw1    : rw0;
        sel_size  = winner ? size1  : size0;
        sel_addr  = winner ? addr1  : addr0;
        sel_wdata = winner ? wdata1 : wdata0;
        sel_oor   = sel_addr > ADDR_TOP;
    end

    // m_en is registered one cycle behind the ACCESS state, so the read
    // capture happens in DONE while the last enabled cycle is on the bus.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            err_pend <= 1'b0;
            cnt      <= 4'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            err      <= 1'b0;
            m_en     <= 1'b0;
            m_rw     <= 1'b1;
            m_size   <= 2'b00;
            mar      <= 32'd0;
            mdr      <= 32'd0;
            rdata    <= 32'd0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt0     <= ~winner;
                        gnt1     <= winner;
                        owner    <= winner;
                        last     <= winner;
                        m_rw     <= sel_rw;
                        m_size   <= sel_size;
                        mar      <= sel_addr;
                        mdr      <= sel_wdata;
                        cnt      <= CNT_LOAD;
                        err_pend <= sel_oor;
                        state    <= sel_oor ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    m_en <= 1'b1;
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                    if (cnt <= 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    m_en <= 1'b0;
                    if (m_rw && !err_pend) begin
                        rdata <= dbus;
                    end
                    done0    <= ~owner;
                    done1    <= owner;
                    err      <= err_pend;
                    err_pend <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
